seven_seg_scan_ctrl: RTL
========================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the 8-digit common-drive seven-segment display.
//  - Holds a double-buffered frame of 8 segment bytes, accepted from the host logic via a load handshake.
//  - Walks the digit commons one at a time with a dead-time guard and 16-level PWM brightness.
//  - Drives oS_COM/oS_ENS (segment order a,b,c,d,e,f,g,dp, bit7=a) directly to the board pins.
// PARAMETERS
//  SCAN_LOG2    13  digit slot length = 2**SCAN_LOG2 clocks (min 5)
//  DEAD_CYC     4   clocks at start of each slot with all commons off (anti-ghosting); < 2**(SCAN_LOG2-4)
//  COM_ACT_LOW  1   1: an enabled common pin = 0
//  SEG_ACT_LOW  0   1: a lit segment pin = 0
// PORTS
//  iCLK         in   1   system clock
//  iRST         in   1   synchronous reset, active-high
//  iLOAD        in   1   1-cycle strobe: capture iSEG_DATA/iBLANK into pending buffer
//  iSEG_DATA    in   64  digit k segments at [8k+7:8k], bit7=a .. bit0=dp
//  iBLANK       in   8   bit k=1 forces digit k dark
//  iBRIGHT      in   4   duty level; digit lit while PWM phase <= iBRIGHT (0=1/16, 15=full)
//  oBUSY        out  1   pending buffer holds data not yet shown
//  oFRAME       out  1   1-cycle pulse at each frame boundary (digit 7 -> 0 wrap)
//  oS_COM       out  8   digit commons, bit k = digit k
//  oS_ENS       out  8   segment enables a..dp
// BEHAVIOUR
//  Reset: prescaler=0, digit idx=0, shadow and pending=0 (all dark), blank latch=0xFF, bright latch=0,
//   oBUSY=0, oFRAME=0, oS_COM=all inactive, oS_ENS=all inactive. Reset wins over every other input.
//  Timebase: prescaler cnt counts 0..2**SCAN_LOG2-1 and wraps. At cnt terminal, idx increments mod 8.
//   Frame boundary = cnt terminal with idx==7. oFRAME is registered and high the cycle after it.
//  PWM phase = cnt[SCAN_LOG2-1 -: 4].
//  lit = (cnt >= DEAD_CYC) && (phase <= bright_latch) && !blank_latch[idx].
//  Outputs are registered, 1-cycle latency from (cnt,idx):
//   - oS_COM: only bit idx active, and only when lit; all others inactive.
//   - oS_ENS: shadow[idx] when lit, else all inactive.
//   - Polarity is applied last via COM_ACT_LOW/SEG_ACT_LOW.
//   - Never more than one common active in any cycle.
//  Load handshake:
//   - iLOAD captures data into pending and sets oBUSY the next cycle.
//   - iLOAD while oBUSY overwrites pending (last write wins); no stall, no error.
//  Transfer: at each frame boundary, if oBUSY then shadow<=pending, blank_latch<=pending blank, oBUSY<=0.
//   iBRIGHT is sampled into bright_latch at every frame boundary, regardless of oBUSY.
//   No tearing: shadow changes only at a boundary.
//  Simultaneous iLOAD + boundary: transfer uses the pending value held before the edge.
//   The new data lands in pending and oBUSY is 1 afterwards (shown one frame later).
//  Mid-operation reset: the scan restarts from digit 0 with a blank display; pending data is discarded.
// STRUCTURE
//  Package seven_seg_pkg: NUM_DIG=8, DIG_IDX_W=3, SEG_W=8, segment bit-index constants (SEG_A..SEG_DP),
//   polarity helper function.
//  Sub-module seven_seg_timebase: prescaler, digit index, frame strobe, PWM phase.
//   Parent seven_seg_scan_ctrl owns the buffers, handshake and pin drive.
// TESTING (SCAN_LOG2=6, DEAD_CYC=2, COM_ACT_LOW=1, SEG_ACT_LOW=0)
//  1 Reset held 3 cycles -> oS_COM=8'hFF, oS_ENS=0, oBUSY=0. Release -> first oFRAME after 512 clocks.
//  2 iLOAD with digit0=8'hFC, iBLANK=0, iBRIGHT=15 -> oBUSY=1 until the boundary.
//     Then during digit0 slot cycles 2..63: oS_COM=8'hFE, oS_ENS=8'hFC; cycles 0..1: oS_COM=8'hFF.
//  3 iBRIGHT=3 -> each digit lit only for cnt 2..15 (14 of 64 cycles); iBRIGHT=0 -> cnt 2..3 only.
//  4 Two iLOADs (0x11.., then 0x22..) in one frame -> only 0x22 pattern ever appears on oS_ENS.
//  5 iLOAD on the boundary cycle -> old pending shown this frame; new data shown next; oBUSY stays 1 between.
//  6 iBLANK=8'h0F -> digits 0..3 never active on oS_COM; every cycle $onehot0(~oS_COM) holds.
//     Mid-frame reset -> outputs dark next cycle.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the eight-digit seven-segment scan controller.
package seven_seg_pkg;

  localparam int NUM_DIG   = 8;
  localparam int DIG_IDX_W = 3;
  localparam int SEG_W     = 8;

  // Segment bit positions inside one digit byte (a is the MSB).
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  function automatic logic [SEG_W-1:0] apply_pol(input logic [SEG_W-1:0] v, input logic act_low);
    return act_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seven_seg_timebase.sv
// Slot prescaler, digit index and frame strobe for the scan controller.
module seven_seg_timebase
  import seven_seg_pkg::*;
#(
  parameter int SCAN_LOG2 = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [SCAN_LOG2-1:0] cnt,
  output logic [DIG_IDX_W-1:0] idx,
  output logic [3:0]           phase,
  output logic                 boundary,
  output logic                 frame
);

  logic term;

  assign term     = &cnt;
  assign boundary = term && (idx == DIG_IDX_W'(NUM_DIG - 1));
  assign phase    = cnt[SCAN_LOG2-1 -: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      frame <= 1'b0;
    end else begin
      cnt   <= cnt + SCAN_LOG2'(1);
      frame <= boundary;
      if (term) idx <= idx + DIG_IDX_W'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Double-buffered, PWM-dimmed, dead-time guarded scan driver for an 8-digit display.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int SCAN_LOG2   = 13,
  parameter int DEAD_CYC    = 4,
  parameter int COM_ACT_LOW = 1,
  parameter int SEG_ACT_LOW = 0
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iLOAD,
  input  logic [NUM_DIG*SEG_W-1:0] iSEG_DATA,
  input  logic [NUM_DIG-1:0]       iBLANK,
  input  logic [3:0]               iBRIGHT,
  output logic                     oBUSY,
  output logic                     oFRAME,
  output logic [NUM_DIG-1:0]       oS_COM,
  output logic [SEG_W-1:0]         oS_ENS
);

  localparam logic [SCAN_LOG2-1:0] DEAD_V  = SCAN_LOG2'(DEAD_CYC);
  localparam logic                 COM_POL = (COM_ACT_LOW != 0);
  localparam logic                 SEG_POL = (SEG_ACT_LOW != 0);

  logic [SCAN_LOG2-1:0]     cnt;
  logic [DIG_IDX_W-1:0]     idx;
  logic [3:0]               phase;
  logic                     boundary;
  logic [NUM_DIG*SEG_W-1:0] pending;
  logic [NUM_DIG*SEG_W-1:0] shadow;
  logic [NUM_DIG-1:0]       pend_blank;
  logic [NUM_DIG-1:0]       blank_latch;
  logic [3:0]               bright_latch;
  logic                     lit;
  logic [NUM_DIG-1:0]       com_raw;
  logic [SEG_W-1:0]         ens_raw;

  seven_seg_timebase #(.SCAN_LOG2(SCAN_LOG2)) u_timebase (
    .clk      (iCLK),
    .rst      (iRST),
    .cnt      (cnt),
    .idx      (idx),
    .phase    (phase),
    .boundary (boundary),
    .frame    (oFRAME)
  );

  // Transfer reads pending before this edge's load, so a load on the boundary shows next frame.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pending      <= '0;
      pend_blank   <= '1;
      shadow       <= '0;
      blank_latch  <= '1;
      bright_latch <= '0;
      oBUSY        <= 1'b0;
    end else begin
      if (boundary) begin
        bright_latch <= iBRIGHT;
        if (oBUSY) begin
          shadow      <= pending;
          blank_latch <= pend_blank;
        end
      end
      if (iLOAD) begin
        pending    <= iSEG_DATA;
        pend_blank <= iBLANK;
        oBUSY      <= 1'b1;
      end else if (boundary) begin
        oBUSY <= 1'b0;
      end
    end
  end

  always_comb begin
    lit     = (cnt >= DEAD_V) && (phase <= bright_latch) && !blank_latch[idx];
    com_raw = '0;
    ens_raw = '0;
    if (lit) begin
      com_raw[idx] = 1'b1;
      ens_raw      = shadow[{idx, 3'b000} +: SEG_W];
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oS_COM <= apply_pol('0, COM_POL);
      oS_ENS <= apply_pol('0, SEG_POL);
    end else begin
      oS_COM <= apply_pol(com_raw, COM_POL);
      oS_ENS <= apply_pol(ens_raw, SEG_POL);
    end
  end

endmodule
